// File: rtl/mprj_uart_tx_if.sv
// mprj_uart_tx_if
//   Byte push port of the user-area UART transmitter.
//   Signals:
//     tx_data  - byte offered by the producer
//     tx_valid - tx_data is valid
//     tx_ready - transmitter FIFO can accept a byte (registered)
//   Handshake: a byte transfers on the rising clock edge where
//   tx_valid && tx_ready are both high. Once tx_valid is raised, the producer
//   holds tx_valid and tx_data stable until that transfer edge. tx_ready does
//   not depend combinationally on tx_valid.
//   Modports: master = producer, slave = transmitter.
interface mprj_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/mprj_uart_tx.sv
// mprj_uart_tx
//   Serial UART transmitter for the user project area. Bytes pushed through
//   the slave port land in a small FIFO and are sent as 8-bit LSB-first frames
//   (start, 8 data, optional parity, 1 or 2 stop bits) on tx.
//   Parameters:
//     FIFO_DEPTH - byte FIFO entries (power of two, >= 2)
//     PARITY     - 0 none, 1 even, 2 odd
//     STOP_BITS  - 1 or 2
//   Ports:
//     clock      - sole clock, rising edge
//     resetb     - asynchronous active-low reset
//     clk_div    - clock cycles per bit, sampled when a byte is popped
//     bus        - byte push port (tx_data / tx_valid / tx_ready)
//     tx         - serial line, idles high
//     busy       - FIFO non-empty or frame in progress
//     fifo_level - FIFO occupancy 0..FIFO_DEPTH
//     dbg_state  - current FSM state encoding
//   All outputs come straight from flops.
module mprj_uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic [15:0]                   clk_div,
  mprj_uart_tx_if.slave                 bus,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [2:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic          PAR_EN    = (PARITY != 0);
  localparam logic          PAR_ODD   = (PARITY == 2);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and pointers (one extra pointer bit separates full/empty)
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [LW-1:0] r_wr_ptr;
  logic [LW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_ready;
  logic [LW-1:0] w_wr_next;
  logic [LW-1:0] w_rd_next;
  logic [LW-1:0] w_level_next;
  logic          w_push;
  logic          w_pop;
  logic          w_nonempty;
  logic [7:0]    w_head;

  // Transmit FSM
  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_div;
  logic [15:0] w_div_next;
  logic [15:0] w_div_clamped;
  logic [15:0] r_baud;
  logic [15:0] w_baud_next;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_next;
  logic [2:0]  w_bit_inc;
  logic        r_stop;
  logic        w_stop_next;
  logic [7:0]  r_byte;
  logic [7:0]  w_byte_next;
  logic        r_tx;
  logic        w_tx_next;
  logic        r_busy;
  logic        w_busy_next;
  logic        w_bit_end;
  logic        w_parity;

  // ---------------------------------------------------------------- FIFO
  // tx_ready is the registered !full, so a push while full is refused even
  // if the FSM pops in the same cycle.
  assign w_push       = bus.tx_valid && r_ready;
  assign w_nonempty   = (r_level != '0);
  assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
  assign w_wr_next    = r_wr_ptr + LW'(w_push);
  assign w_rd_next    = r_rd_ptr + LW'(w_pop);
  assign w_level_next = w_wr_next - w_rd_next;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.tx_data;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_level  <= w_level_next;
      r_ready  <= (w_level_next != DEPTH_L);
    end
  end

  // ---------------------------------------------------------------- FSM
  assign w_div_clamped = (clk_div < 16'd4) ? 16'd4 : clk_div;
  // The baud counter reloads at every bit boundary, so bits never drift.
  assign w_bit_end     = (r_baud == (r_div - 16'd1));
  assign w_bit_inc     = r_bit + 3'd1;
  assign w_parity      = (^r_byte) ^ PAR_ODD;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_IDLE;
      r_div   <= 16'd4;
      r_baud  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_byte  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_div   <= w_div_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_stop  <= w_stop_next;
      r_byte  <= w_byte_next;
      r_tx    <= w_tx_next;
      r_busy  <= w_busy_next;
    end
  end

  // Next-state logic also computes the next tx level so that tx is a flop.
  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_stop_next  = r_stop;
    w_byte_next  = r_byte;
    w_tx_next    = r_tx;
    w_pop        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (w_nonempty) begin
          w_pop        = 1'b1;
          w_byte_next  = w_head;
          w_div_next   = w_div_clamped;
          w_baud_next  = '0;
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_DATA;
          w_tx_next    = r_byte[0];
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            if (PAR_EN) begin
              w_state_next = S_PARITY;
              w_tx_next    = w_parity;
            end else begin
              w_state_next = S_STOP;
              w_stop_next  = 1'b0;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_bit_next = w_bit_inc;
            w_tx_next  = r_byte[w_bit_inc];
          end
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_stop_next  = 1'b0;
          w_state_next = S_STOP;
          w_tx_next    = 1'b1;
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_stop == STOP_LAST) begin
            // Queued bytes go straight into a new start bit, no idle bit.
            if (w_nonempty) begin
              w_pop        = 1'b1;
              w_byte_next  = w_head;
              w_div_next   = w_div_clamped;
              w_state_next = S_START;
              w_tx_next    = 1'b0;
            end else begin
              w_state_next = S_IDLE;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_stop_next = 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  assign w_busy_next = (w_state_next != S_IDLE) || (w_level_next != '0);

  assign bus.tx_ready = r_ready;
  assign tx           = r_tx;
  assign busy         = r_busy;
  assign fifo_level   = r_level;
  assign dbg_state    = r_state;

endmodule
